// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and instruction-fetch sequencer.
// Holds the PC, fetches the word at PC from instruction memory, presents it
// to decode with a valid flag, and traps misaligned branch/jump targets.
//
// Instruction-memory handshake: ImemReq is a registered request that stays
// high until the cycle in which ImemAck=1 is sampled on a rising edge. The
// word on ImemRdata is captured on that same edge. ImemAck while ImemReq=0
// has no effect. An open request is never withdrawn except by reset.
module pc_fetch_unit #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Rstn,
  input  logic [DATA_WIDTH-1:0] NewPc,
  input  logic                  Advance,
  input  logic                  Stall,
  output logic                  ImemReq,
  output logic [DATA_WIDTH-1:0] ImemAddr,
  input  logic                  ImemAck,
  input  logic [DATA_WIDTH-1:0] ImemRdata,
  output logic [DATA_WIDTH-1:0] Pc,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic                  InstrValid,
  output logic                  MisalignFault,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Word-aligned reset PC; the low two bits of RESET_PC are ignored.
  localparam logic [DATA_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[DATA_WIDTH-1:2], 2'b00};
  // Instruction presented before the first fetch completes (addi x0,x0,0).
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  state_t state;

  // The fetch address is the PC itself; no separate address register.
  assign ImemAddr  = Pc;
  assign dbg_state = state;

  // Sequencer: all state and registered outputs are updated together here.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state         <= S_IDLE;
      Pc            <= RESET_PC_ALIGNED;
      Instr         <= NOP_INSTR;
      InstrValid    <= 1'b0;
      ImemReq       <= 1'b0;
      MisalignFault <= 1'b0;
    end else begin
      case (state)
        // First cycle after reset: open the fetch at the reset PC.
        S_IDLE: begin
          state   <= S_REQ;
          ImemReq <= 1'b1;
        end

        // Waiting for memory. Stall and Advance do not affect an open request.
        S_REQ: begin
          if (ImemAck) begin
            Instr      <= ImemRdata;
            InstrValid <= 1'b1;
            ImemReq    <= 1'b0;
            state      <= S_VALID;
          end
        end

        // Instruction held for decode until the core retires it.
        S_VALID: begin
          if (Advance && !Stall) begin
            InstrValid <= 1'b0;
            if (NewPc[1:0] == 2'b00) begin
              // NewPc is taken verbatim; PC+4/target math lives upstream.
              Pc      <= NewPc;
              ImemReq <= 1'b1;
              state   <= S_REQ;
            end else begin
              // Misaligned target: keep the last good PC and stop fetching.
              MisalignFault <= 1'b1;
              state         <= S_FAULT;
            end
          end
        end

        // Terminal until reset; outputs simply hold.
        S_FAULT: begin
          ImemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end

        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed walk through the fetch/retire scenarios,
// followed by a randomized phase, all checked against a behavioural model.
module tb_pc_fetch_unit;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rstn = 1'b0;
  always #5 Clk = ~Clk;

  logic [W-1:0] NewPc = '0;
  logic         Advance = 1'b0;
  logic         Stall = 1'b0;
  logic         ImemReq;
  logic [W-1:0] ImemAddr;
  logic         ImemAck = 1'b0;
  logic [W-1:0] ImemRdata = '0;
  logic [W-1:0] Pc;
  logic [W-1:0] Instr;
  logic         InstrValid;
  logic         MisalignFault;
  logic [1:0]   dbg_state;

  pc_fetch_unit #(.DATA_WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Rstn(Rstn), .NewPc(NewPc), .Advance(Advance), .Stall(Stall),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
    .Pc(Pc), .Instr(Instr), .InstrValid(InstrValid), .MisalignFault(MisalignFault),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural reference model ----------------
  // The model tracks what the core should observe: whether the unit has just
  // come out of reset, whether a fetch is outstanding, whether a word is
  // ready for decode, and whether a bad target has been seen.
  bit           m_fresh;
  bit           m_fetching;
  bit           m_ready;
  bit           m_fault;
  logic [W-1:0] m_pc;
  logic [W-1:0] m_instr;

  int total_checks = 0;
  int passed_checks = 0;

  task automatic model_reset();
    m_fresh    = 1'b1;
    m_fetching = 1'b0;
    m_ready    = 1'b0;
    m_fault    = 1'b0;
    m_pc       = RESET_PC & ~W'(3);
    m_instr    = NOP;
  endtask

  // Apply the rules for one rising edge using the inputs presented to it.
  task automatic model_edge();
    if (m_fault) begin
      // nothing moves until reset
    end else if (m_fresh) begin
      m_fresh    = 1'b0;
      m_fetching = 1'b1;
    end else if (m_fetching) begin
      if (ImemAck) begin
        m_instr    = ImemRdata;
        m_fetching = 1'b0;
        m_ready    = 1'b1;
      end
    end else if (m_ready && Advance && !Stall) begin
      m_ready = 1'b0;
      if (NewPc % 4 == 0) begin
        m_pc       = NewPc;
        m_fetching = 1'b1;
      end else begin
        m_fault = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string where);
    check({where, ".req"},    W'(ImemReq),       W'(m_fetching));
    check({where, ".addr"},   ImemAddr,          m_pc);
    check({where, ".pc"},     Pc,                m_pc);
    check({where, ".instr"},  Instr,             m_instr);
    check({where, ".valid"},  W'(InstrValid),    W'(m_ready));
    check({where, ".fault"},  W'(MisalignFault), W'(m_fault));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model with the inputs now on the pins, let the
  // edge happen, then compare 1ns later. New inputs go on after that.
  task automatic step(input string where);
    model_edge();
    @(posedge Clk);
    #1;
    check_all(where);
  endtask

  task automatic do_reset();
    #2;
    Rstn = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    @(posedge Clk);
    #1;
    Rstn = 1'b1;
  endtask

  task automatic retire(input logic [W-1:0] target, input string where);
    NewPc   = target;
    Advance = 1'b1;
    step(where);
    Advance = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(posedge Clk);
    #1;
    check_all("reset_hold");

    // Zero-wait fetch after reset.
    ImemAck   = 1'b1;
    ImemRdata = 32'h00A0_0093;
    Rstn      = 1'b1;
    step("boot_c1");                  // REQ, addr 0
    check("boot_c1.req_hi", W'(ImemReq), W'(1));
    step("boot_c2");                  // VALID, instr captured
    check("boot_c2.instr", Instr, 32'h00A0_0093);

    // Sequential retirement: one bubble per instruction.
    ImemRdata = 32'h1111_0013;
    retire(32'h4, "seq4_req");
    check("seq4.addr", ImemAddr, 32'h4);
    step("seq4_valid");
    ImemRdata = 32'h2222_0013;
    retire(32'h8, "seq8_req");
    check("seq8.addr", ImemAddr, 32'h8);
    step("seq8_valid");

    // Taken branch, then wait states with Stall asserted during the request.
    retire(32'h100, "br_req");
    check("br.pc", Pc, 32'h100);
    ImemAck = 1'b0;
    Stall   = 1'b1;
    for (int i = 0; i < 3; i++) step("wait");
    check("wait.req_held", W'(ImemReq), W'(1));
    ImemAck   = 1'b1;
    ImemRdata = 32'h3333_0013;
    step("wait_ack");
    check("wait_ack.valid", W'(InstrValid), W'(1));

    // Stall in VALID blocks Advance.
    NewPc   = 32'h200;
    Advance = 1'b1;
    step("stall_v1");
    step("stall_v2");
    check("stall.pc", Pc, 32'h100);
    Stall   = 1'b0;
    Advance = 1'b0;

    // Misaligned target traps and freezes.
    retire(32'h102, "mis");
    check("mis.fault", W'(MisalignFault), W'(1));
    check("mis.pc", Pc, 32'h100);
    Advance = 1'b1;
    NewPc   = 32'h300;
    for (int i = 0; i < 4; i++) step("fault_hold");
    Advance = 1'b0;

    // Reset clears the fault; then reset asserted in the middle of a request.
    do_reset();
    ImemAck = 1'b0;
    step("rst_req");
    step("rst_req_wait");
    #2;
    Rstn = 1'b0;
    model_reset();
    #1;
    check("midreq.req_drop", W'(ImemReq), W'(0));
    check("midreq.pc", Pc, RESET_PC);
    check_all("midreq");
    @(posedge Clk);
    #1;
    Rstn      = 1'b1;
    ImemAck   = 1'b1;
    ImemRdata = 32'h4444_0013;
    step("restart_req");
    step("restart_valid");

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      Advance   = ($urandom_range(0, 2) != 0);
      Stall     = ($urandom_range(0, 3) == 0);
      ImemAck   = ($urandom_range(0, 2) != 0);
      ImemRdata = $urandom;
      if ($urandom_range(0, 39) == 0)
        NewPc = ($urandom & ~W'(3)) | W'($urandom_range(1, 3));
      else
        NewPc = $urandom & ~W'(3);
      if (m_fault && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        step("rand");
      end
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
